// File: rtl/image_resize_line_buf.sv
// Circular multi-row pixel store feeding vertical interpolation; read latency 1 + OUTPUT_REG cycles.
// Writes stall (wr_ready low) while every slot holds a completed row; reads need two stored rows.
module image_resize_line_buf #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_LINES  = 4,
  parameter int OUTPUT_REG = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_valid,
  input  logic                          wr_last,
  output logic                          wr_ready,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic                          rd_line_adv,
  output logic [DATA_WIDTH-1:0]         rd_data0,
  output logic [DATA_WIDTH-1:0]         rd_data1,
  output logic                          rd_valid,
  output logic [ADDR_WIDTH:0]           rd_line_len,
  output logic [$clog2(NUM_LINES):0]    lines_avail,
  output logic                          empty,
  output logic                          full,
  output logic                          len_err
);

  localparam int LW    = $clog2(NUM_LINES);
  localparam int CW    = LW + 1;
  localparam int DEPTH = NUM_LINES << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   len [NUM_LINES];

  logic [ADDR_WIDTH-1:0] wr_col;
  logic [LW-1:0]         wr_line;
  logic [LW-1:0]         rd_line;
  logic [LW-1:0]         rd_line_nxt;
  logic                  wr_acc;
  logic                  row_done;
  logic                  rd_acc;
  logic                  adv_acc;

  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_d0;
  logic [DATA_WIDTH-1:0] s1_d1;

  assign full        = (lines_avail == CW'(NUM_LINES));
  assign empty       = (lines_avail == '0);
  assign wr_ready    = !full;
  assign wr_acc      = wr_valid && wr_ready && !flush;
  // A row also closes when its last column is written, even without wr_last.
  assign row_done    = wr_acc && (wr_last || (&wr_col));
  assign rd_acc      = rd_en && (lines_avail >= CW'(2)) && !flush;
  assign adv_acc     = rd_line_adv && !empty && !flush;
  assign rd_line_nxt = rd_line + LW'(1);
  assign rd_line_len = empty ? '0 : len[rd_line];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_col      <= '0;
      wr_line     <= '0;
      rd_line     <= '0;
      lines_avail <= '0;
      len_err     <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
        len[i] <= '0;
      end
    end else if (flush) begin
      wr_col      <= '0;
      wr_line     <= '0;
      rd_line     <= '0;
      lines_avail <= '0;
      len_err     <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_col <= row_done ? '0 : wr_col + ADDR_WIDTH'(1);
      end
      if (row_done) begin
        len[wr_line] <= {1'b0, wr_col} + (ADDR_WIDTH + 1)'(1);
        wr_line      <= wr_line + LW'(1);
        if (!wr_last) begin
          len_err <= 1'b1;
        end
      end
      if (adv_acc) begin
        rd_line <= rd_line_nxt;
      end
      case ({row_done, adv_acc})
        2'b10:   lines_avail <= lines_avail + CW'(1);
        2'b01:   lines_avail <= lines_avail - CW'(1);
        default: lines_avail <= lines_avail;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wr_line, wr_col}] <= wr_data;
    end
  end

  // Flush does not cancel a read already accepted; the pipeline drains on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_d0  <= '0;
      s1_d1  <= '0;
    end else begin
      s1_vld <= rd_acc;
      if (rd_acc) begin
        s1_d0 <= mem[{rd_line, rd_addr}];
        s1_d1 <= mem[{rd_line_nxt, rd_addr}];
      end
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic                  s2_vld;
      logic [DATA_WIDTH-1:0] s2_d0;
      logic [DATA_WIDTH-1:0] s2_d1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld <= 1'b0;
          s2_d0  <= '0;
          s2_d1  <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_d0 <= s1_d0;
            s2_d1 <= s1_d1;
          end
        end
      end

      assign rd_valid = s2_vld;
      assign rd_data0 = s2_d0;
      assign rd_data1 = s2_d1;
    end else begin : g_noreg
      assign rd_valid = s1_vld;
      assign rd_data0 = s1_d0;
      assign rd_data1 = s1_d1;
    end
  endgenerate

endmodule

// File: tb/tb_image_resize_line_buf.sv
// Bench for image_resize_line_buf: random pixels against a row-queue model of completed rows.
module tb_image_resize_line_buf;

  localparam int DW     = 24;
  localparam int AW     = 11;
  localparam int NL     = 4;
  localparam int OREG   = 0;
  localparam int LAT    = OREG + 1;
  localparam int MAXLEN = 1 << AW;
  localparam int CW     = $clog2(NL) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_last = 1'b0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_line_adv = 1'b0;
  logic [DW-1:0] rd_data0;
  logic [DW-1:0] rd_data1;
  logic          rd_valid;
  logic [AW:0]   rd_line_len;
  logic [CW-1:0] lines_avail;
  logic          empty;
  logic          full;
  logic          len_err;

  image_resize_line_buf #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL), .OUTPUT_REG(OREG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_line_adv(rd_line_adv),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_valid(rd_valid),
    .rd_line_len(rd_line_len), .lines_avail(lines_avail),
    .empty(empty), .full(full), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: queue of completed row ids (oldest first), per-row length and pixels.
  int            rows_q[$];
  int            row_len[int];
  logic [DW-1:0] pix[int];
  int            cur_id = 0;
  int            cur_col = 0;
  int            next_id = 1;
  bit            err_m = 1'b0;

  typedef struct {
    int            due;
    bit            c0;
    bit            c1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } rd_exp_t;
  rd_exp_t pend[$];

  int n_chk = 0;
  int n_pass = 0;

  function automatic int key(input int id, input int col);
    return id * 4096 + col;
  endfunction

  task automatic model_clear();
    rows_q.delete();
    cur_col = 0;
    cur_id  = next_id;
    next_id++;
    err_m   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, return at the following negedge.
  task automatic apply(input bit wv, input logic [DW-1:0] wd, input bit wl,
                       input bit re, input int ra, input bit adv, input bit fl);
    rd_exp_t e;
    bit      acc_w;
    wr_valid = wv; wr_data = wd; wr_last = wl;
    rd_en = re; rd_addr = AW'(ra); rd_line_adv = adv; flush = fl;
    if (fl) begin
      model_clear();
    end else begin
      acc_w = wv && (rows_q.size() < NL);
      if (re && rows_q.size() >= 2) begin
        e.due = cyc + LAT;
        e.c0  = ra < row_len[rows_q[0]];
        e.c1  = ra < row_len[rows_q[1]];
        e.d0  = e.c0 ? pix[key(rows_q[0], ra)] : '0;
        e.d1  = e.c1 ? pix[key(rows_q[1], ra)] : '0;
        pend.push_back(e);
      end
      if (adv && rows_q.size() >= 1) void'(rows_q.pop_front());
      if (acc_w) begin
        pix[key(cur_id, cur_col)] = wd;
        cur_col++;
        if (wl || cur_col == MAXLEN) begin
          row_len[cur_id] = cur_col;
          if (!wl) err_m = 1'b1;
          rows_q.push_back(cur_id);
          cur_id = next_id;
          next_id++;
          cur_col = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    apply(0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_row(input int n, input bit with_last, input int pat);
    logic [DW-1:0] d;
    for (int c = 0; c < n; c++) begin
      d = (pat >= 0) ? {12'(pat), 12'(c)} : DW'($urandom);
      apply(1, d, with_last && (c == n - 1), 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0b want 0", rd_valid); else n_pass++;
    n_chk++; if (lines_avail !== '0) $display("FAIL reset_lines_avail got %0d want 0", lines_avail); else n_pass++;
    n_chk++; if (empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", empty); else n_pass++;
    n_chk++; if (full !== 1'b0) $display("FAIL reset_full got %0b want 0", full); else n_pass++;
    n_chk++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %0b want 1", wr_ready); else n_pass++;
    n_chk++; if (len_err !== 1'b0) $display("FAIL reset_len_err got %0b want 0", len_err); else n_pass++;
    n_chk++; if (rd_line_len !== '0) $display("FAIL reset_rd_line_len got %0d want 0", rd_line_len); else n_pass++;
    n_chk++; if (rd_data0 !== '0 || rd_data1 !== '0) $display("FAIL reset_rd_data got %h/%h want 0/0", rd_data0, rd_data1); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lengths();
    write_row(8, 1, -1);
    write_row(5, 1, -1);
    n_chk++; if (len_err !== 1'b0) $display("FAIL lengths_err_early got %0b want 0", len_err); else n_pass++;
    write_row(MAXLEN, 0, -1);
    n_chk++; if (lines_avail !== CW'(3)) $display("FAIL lengths_avail got %0d want 3", lines_avail); else n_pass++;
    n_chk++; if (rd_line_len !== (AW+1)'(8)) $display("FAIL lengths_rd_line_len got %0d want 8", rd_line_len); else n_pass++;
    n_chk++; if (len_err !== err_m) $display("FAIL lengths_len_err got %0b want %0b", len_err, err_m); else n_pass++;
    n_chk++; if (wr_ready !== 1'b1) $display("FAIL lengths_wr_ready got %0b want 1", wr_ready); else n_pass++;
    apply(0, '0, 0, 0, 0, 0, 1);
    n_chk++; if (lines_avail !== '0) $display("FAIL flush_avail got %0d want 0", lines_avail); else n_pass++;
    n_chk++; if (len_err !== 1'b0) $display("FAIL flush_len_err got %0b want 0", len_err); else n_pass++;
    idle();
  endtask

  task automatic test_read_data();
    rd_exp_t       e;
    bit            exp_v;
    int            run;
    int            max_run;
    logic [DW-1:0] want0;
    logic [DW-1:0] want1;
    write_row(8, 1, 0);
    write_row(8, 1, 1);
    want0 = {12'd0, 12'd4};
    want1 = {12'd1, 12'd4};
    apply(0, '0, 0, 1, 4, 0, 0);
    for (int k = 1; k < LAT; k++) begin
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL read_latency_early got %0b want 0", rd_valid); else n_pass++;
      idle();
    end
    n_chk++; if (rd_valid !== 1'b1) $display("FAIL read_latency got %0b want 1", rd_valid); else n_pass++;
    n_chk++; if (rd_data0 !== want0) $display("FAIL read_data0 got %h want %h", rd_data0, want0); else n_pass++;
    n_chk++; if (rd_data1 !== want1) $display("FAIL read_data1 got %h want %h", rd_data1, want1); else n_pass++;
    pend.delete();
    run = 0; max_run = 0;
    for (int i = 0; i < 8 + LAT + 1; i++) begin
      if (i < 8) apply(0, '0, 0, 1, i, 0, 0); else idle();
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      n_chk++; if (rd_valid !== exp_v) $display("FAIL b2b_valid cyc %0d got %0b want %0b", cyc, rd_valid, exp_v); else n_pass++;
      if (exp_v) begin
        e = pend.pop_front();
        if (e.c0) begin n_chk++; if (rd_data0 !== e.d0) $display("FAIL b2b_data0 got %h want %h", rd_data0, e.d0); else n_pass++; end
        if (e.c1) begin n_chk++; if (rd_data1 !== e.d1) $display("FAIL b2b_data1 got %h want %h", rd_data1, e.d1); else n_pass++; end
      end
      run = rd_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    n_chk++; if (max_run != 8) $display("FAIL b2b_run got %0d want 8", max_run); else n_pass++;
    want0 = {12'd0, 12'd7};
    n_chk++; if (rd_data0 !== want0) $display("FAIL read_hold got %h want %h", rd_data0, want0); else n_pass++;
    apply(0, '0, 0, 0, 0, 0, 1);
    idle();
  endtask

  task automatic test_full();
    rd_exp_t       e;
    bit            exp_v;
    logic [DW-1:0] held;
    for (int r = 0; r < NL; r++) write_row($urandom_range(2, 6), 1, -1);
    n_chk++; if (full !== 1'b1) $display("FAIL full_flag got %0b want 1", full); else n_pass++;
    n_chk++; if (wr_ready !== 1'b0) $display("FAIL full_wr_ready got %0b want 0", wr_ready); else n_pass++;
    held = DW'($urandom);
    for (int k = 0; k < 3; k++) begin
      apply(1, held, 1, 0, 0, 0, 0);
      n_chk++; if (lines_avail !== CW'(NL)) $display("FAIL full_hold_avail got %0d want %0d", lines_avail, NL); else n_pass++;
    end
    apply(1, held, 1, 0, 0, 1, 0);
    n_chk++; if (wr_ready !== 1'b1) $display("FAIL full_release_ready got %0b want 1", wr_ready); else n_pass++;
    n_chk++; if (lines_avail !== CW'(NL - 1)) $display("FAIL full_release_avail got %0d want %0d", lines_avail, NL - 1); else n_pass++;
    apply(1, held, 1, 0, 0, 0, 0);
    n_chk++; if (full !== 1'b1) $display("FAIL full_refill got %0b want 1", full); else n_pass++;
    apply(0, '0, 0, 0, 0, 1, 0);
    apply(0, '0, 0, 0, 0, 1, 0);
    for (int i = 0; i < LAT + 1; i++) begin
      if (i == 0) apply(0, '0, 0, 1, 0, 0, 0); else idle();
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      n_chk++; if (rd_valid !== exp_v) $display("FAIL full_rd_valid got %0b want %0b", rd_valid, exp_v); else n_pass++;
      if (exp_v) begin
        e = pend.pop_front();
        if (e.c0) begin n_chk++; if (rd_data0 !== e.d0) $display("FAIL full_data0 got %h want %h", rd_data0, e.d0); else n_pass++; end
      end
    end
    n_chk++; if (rd_data1 !== held) $display("FAIL full_held_pixel got %h want %h", rd_data1, held); else n_pass++;
    apply(0, '0, 0, 0, 0, 0, 1);
    idle();
  endtask

  task automatic test_coincide();
    write_row(6, 1, -1);
    write_row(9, 1, -1);
    for (int c = 0; c < 3; c++) apply(1, DW'($urandom), c == 2, 0, 0, c == 2, 0);
    n_chk++; if (lines_avail !== CW'(2)) $display("FAIL coincide_avail got %0d want 2", lines_avail); else n_pass++;
    n_chk++; if (rd_line_len !== (AW+1)'(9)) $display("FAIL coincide_len got %0d want 9", rd_line_len); else n_pass++;
    apply(0, '0, 0, 0, 0, 0, 1);
    idle();
  endtask

  task automatic test_ignore();
    write_row(4, 1, -1);
    apply(0, '0, 0, 1, 0, 0, 0);
    for (int k = 0; k <= LAT; k++) begin
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL ignore_read got %0b want 0", rd_valid); else n_pass++;
      idle();
    end
    apply(0, '0, 0, 0, 0, 0, 1);
    apply(0, '0, 0, 0, 0, 1, 0);
    n_chk++; if (lines_avail !== '0) $display("FAIL ignore_adv_avail got %0d want 0", lines_avail); else n_pass++;
    n_chk++; if (empty !== 1'b1) $display("FAIL ignore_adv_empty got %0b want 1", empty); else n_pass++;
    n_chk++; if (rd_line_len !== '0) $display("FAIL ignore_adv_len got %0d want 0", rd_line_len); else n_pass++;
  endtask

  task automatic test_stream();
    rd_exp_t e;
    bit      exp_v;
    bit      wv, wl, re, adv, done;
    int      rows_done;
    rows_done = 0; done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      wv  = (rows_done < 10) && (rows_q.size() < NL);
      wl  = wv && (cur_col == 15);
      re  = rows_q.size() >= 2;
      adv = (rows_q.size() >= 2) && (($urandom_range(0, 2) == 0) || rows_q.size() == NL || rows_done == 10);
      if (wl) rows_done++;
      apply(wv, DW'($urandom), wl, re, $urandom_range(0, 15), adv, 0);
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      n_chk++; if (rd_valid !== exp_v) $display("FAIL stream_valid cyc %0d got %0b want %0b", cyc, rd_valid, exp_v); else n_pass++;
      if (exp_v) begin
        e = pend.pop_front();
        if (e.c0) begin n_chk++; if (rd_data0 !== e.d0) $display("FAIL stream_data0 cyc %0d got %h want %h", cyc, rd_data0, e.d0); else n_pass++; end
        if (e.c1) begin n_chk++; if (rd_data1 !== e.d1) $display("FAIL stream_data1 cyc %0d got %h want %h", cyc, rd_data1, e.d1); else n_pass++; end
      end
      n_chk++; if (lines_avail !== CW'(rows_q.size())) $display("FAIL stream_avail got %0d want %0d", lines_avail, rows_q.size()); else n_pass++;
      done = (rows_done == 10) && (rows_q.size() < 2) && (pend.size() == 0);
    end
    n_chk++; if (!done) $display("FAIL stream_timeout rows %0d want 10 drained", rows_done); else n_pass++;
    apply(0, '0, 0, 0, 0, 0, 1);
    idle();
  endtask

  task automatic test_flush();
    rd_exp_t       e;
    bit            exp_v;
    logic [DW-1:0] want;
    write_row(5, 1, -1);
    write_row(5, 1, -1);
    for (int c = 0; c < 3; c++) apply(1, DW'($urandom), 0, 0, 0, 0, 0);
    apply(1, DW'($urandom), 0, 0, 0, 0, 1);
    n_chk++; if (lines_avail !== '0) $display("FAIL midflush_avail got %0d want 0", lines_avail); else n_pass++;
    n_chk++; if (empty !== 1'b1) $display("FAIL midflush_empty got %0b want 1", empty); else n_pass++;
    write_row(4, 1, 7);
    write_row(4, 1, 8);
    n_chk++; if (rd_line_len !== (AW+1)'(4)) $display("FAIL midflush_len got %0d want 4", rd_line_len); else n_pass++;
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 4) apply(0, '0, 0, 1, i, 0, 0); else idle();
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      n_chk++; if (rd_valid !== exp_v) $display("FAIL midflush_valid got %0b want %0b", rd_valid, exp_v); else n_pass++;
      if (exp_v) begin
        e = pend.pop_front();
        if (e.c0) begin n_chk++; if (rd_data0 !== e.d0) $display("FAIL midflush_data0 got %h want %h", rd_data0, e.d0); else n_pass++; end
        if (e.c1) begin n_chk++; if (rd_data1 !== e.d1) $display("FAIL midflush_data1 got %h want %h", rd_data1, e.d1); else n_pass++; end
      end
    end
    want = {12'd7, 12'd3};
    n_chk++; if (rd_data0 !== want) $display("FAIL midflush_col got %h want %h", rd_data0, want); else n_pass++;
    apply(0, '0, 0, 0, 0, 0, 1);
    idle();
  endtask

  task automatic test_reset_midread();
    write_row(4, 1, -1);
    write_row(4, 1, -1);
    for (int i = 0; i < 3; i++) apply(0, '0, 0, 1, i, 0, 0);
    n_chk++; if (rd_valid !== 1'b1) $display("FAIL midreset_pre got %0b want 1", rd_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL midreset_valid got %0b want 0", rd_valid); else n_pass++;
    n_chk++; if (lines_avail !== '0) $display("FAIL midreset_avail got %0d want 0", lines_avail); else n_pass++;
    pend.delete();
    model_clear();
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL postreset_valid got %0b want 0", rd_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lengths();
    test_read_data();
    test_full();
    test_coincide();
    test_ignore();
    test_stream();
    test_flush();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
